// File: rtl/div_rem_sequencer_pkg.sv
// Shared encodings for the divide/remainder sequencer: op codes, FSM states and
// the flush length that covers one worst-case in-flight core operation.
package div_rem_sequencer_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [2:0] S_FLUSH  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Core latency is XLEN+2 and done stays high for two cycles; one extra cycle of margin.
  function automatic int flush_cycles(input int xlen);
    return xlen + 3;
  endfunction

endpackage

// File: rtl/div_rem_sequencer_fixup.sv
// Combinational sign handling around the unsigned divider core: operand preparation
// (W extension, magnitudes, special cases) and result negation/selection.
module div_operand_prep #(
  parameter int XLEN = 64
) (
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_abs_a,
  output logic [XLEN-1:0] o_abs_b,
  output logic            o_neg_q,
  output logic            o_neg_r,
  output logic            o_special,
  output logic [XLEN-1:0] o_special_q,
  output logic [XLEN-1:0] o_special_r
);

  logic            w_signed;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_min;
  logic            w_sign_a;
  logic            w_sign_b;
  logic            w_div0;
  logic            w_ovf;

  assign w_signed = ~i_op[0];

  always_comb begin
    w_a = i_rs1;
    w_b = i_rs2;
    if (i_word) begin
      w_a = {{(XLEN-32){w_signed & i_rs1[31]}}, i_rs1[31:0]};
      w_b = {{(XLEN-32){w_signed & i_rs2[31]}}, i_rs2[31:0]};
    end
  end

  // Most-negative value as it appears after W sign extension.
  assign w_min = i_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};

  assign w_sign_a = w_signed & w_a[XLEN-1];
  assign w_sign_b = w_signed & w_b[XLEN-1];
  assign o_abs_a  = w_sign_a ? (~w_a + 1'b1) : w_a;
  assign o_abs_b  = w_sign_b ? (~w_b + 1'b1) : w_b;
  assign o_neg_q  = w_sign_a ^ w_sign_b;
  assign o_neg_r  = w_sign_a;

  assign w_div0      = (w_b == '0);
  assign w_ovf       = w_signed & (w_b == '1) & (w_a == w_min);
  assign o_special   = w_div0 | w_ovf;
  assign o_special_q = w_div0 ? '1 : w_a;
  assign o_special_r = w_div0 ? w_a : '0;

endmodule

module div_result_fix #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_r,
  input  logic            i_neg_q,
  input  logic            i_neg_r,
  input  logic            i_is_rem,
  input  logic            i_word,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;
  logic [XLEN-1:0] w_sel;

  assign w_q      = i_neg_q ? (~i_q + 1'b1) : i_q;
  assign w_r      = i_neg_r ? (~i_r + 1'b1) : i_r;
  assign w_sel    = i_is_rem ? w_r : w_q;
  assign o_result = i_word ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;

endmodule

// File: rtl/div_rem_sequencer.sv
// RV64 M-extension DIV/DIVU/REM/REMU(+W) sequencer wrapped around an unsigned,
// reset-less divider core: screens special cases, launches the core, sign-fixes results.
module div_rem_sequencer
  import div_rem_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            core_start,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  input  logic            core_done,
  input  logic [XLEN-1:0] core_quotient,
  input  logic [XLEN-1:0] core_remainder,
  output logic [2:0]      dbg_state
);

  localparam int                 FLUSH_N    = flush_cycles(XLEN);
  localparam int                 FLUSH_W    = $clog2(FLUSH_N + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_N);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);

  logic [2:0]         r_state;
  logic [FLUSH_W-1:0] r_flush_cnt;
  logic               r_is_rem;
  logic               r_word;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [XLEN-1:0]    r_dividend;
  logic [XLEN-1:0]    r_divisor;
  logic [XLEN-1:0]    r_result;
  logic               r_done_d;

  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_neg_q;
  logic            w_neg_r;
  logic            w_special;
  logic [XLEN-1:0] w_spec_q;
  logic [XLEN-1:0] w_spec_r;
  logic [XLEN-1:0] w_fix_q;
  logic [XLEN-1:0] w_fix_r;
  logic            w_fix_neg_q;
  logic            w_fix_neg_r;
  logic            w_fix_rem;
  logic            w_fix_word;
  logic [XLEN-1:0] w_fix_result;
  logic            w_done_rise;

  div_operand_prep #(.XLEN(XLEN)) u_prep (
    .i_op        (req_op),
    .i_word      (req_word),
    .i_rs1       (req_rs1),
    .i_rs2       (req_rs2),
    .o_abs_a     (w_abs_a),
    .o_abs_b     (w_abs_b),
    .o_neg_q     (w_neg_q),
    .o_neg_r     (w_neg_r),
    .o_special   (w_special),
    .o_special_q (w_spec_q),
    .o_special_r (w_spec_r)
  );

  // In IDLE the fixup path shapes the special-case value; otherwise it shapes core output.
  always_comb begin
    w_fix_q     = core_quotient;
    w_fix_r     = core_remainder;
    w_fix_neg_q = r_neg_q;
    w_fix_neg_r = r_neg_r;
    w_fix_rem   = r_is_rem;
    w_fix_word  = r_word;
    if (r_state == S_IDLE) begin
      w_fix_q     = w_spec_q;
      w_fix_r     = w_spec_r;
      w_fix_neg_q = 1'b0;
      w_fix_neg_r = 1'b0;
      w_fix_rem   = req_op[1];
      w_fix_word  = req_word;
    end
  end

  div_result_fix #(.XLEN(XLEN)) u_fix (
    .i_q      (w_fix_q),
    .i_r      (w_fix_r),
    .i_neg_q  (w_fix_neg_q),
    .i_neg_r  (w_fix_neg_r),
    .i_is_rem (w_fix_rem),
    .i_word   (w_fix_word),
    .o_result (w_fix_result)
  );

  // Both ports use valid/ready: a transfer happens on any clock edge where valid and
  // ready are both high; resp_valid and resp_result stay stable until that edge.
  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = (r_state == S_RESP);
  assign resp_result   = r_result;
  assign core_start    = (r_state == S_LAUNCH) & ~core_done;
  assign core_dividend = r_dividend;
  assign core_divisor  = r_divisor;
  assign dbg_state     = r_state;
  assign w_done_rise   = core_done & ~r_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FLUSH;
      r_flush_cnt <= FLUSH_INIT;
      r_is_rem    <= 1'b0;
      r_word      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_result    <= '0;
      r_done_d    <= 1'b0;
    end else begin
      r_done_d <= core_done;
      case (r_state)
        S_FLUSH: begin
          if (r_flush_cnt == FLUSH_ONE) r_state <= S_IDLE;
          else                          r_flush_cnt <= r_flush_cnt - FLUSH_ONE;
        end
        S_IDLE: begin
          if (req_valid) begin
            r_is_rem   <= req_op[1];
            r_word     <= req_word;
            r_neg_q    <= w_neg_q;
            r_neg_r    <= w_neg_r;
            r_dividend <= w_abs_a;
            r_divisor  <= w_abs_b;
            if (w_special) begin
              r_result <= w_fix_result;
              r_state  <= S_RESP;
            end else begin
              r_state  <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (!core_done) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done_rise) begin
            r_result <= w_fix_result;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Directed bench for div_rem_sequencer with a behavioural unsigned divider core
// (XLEN+2 latency, two-cycle done, valid data only on the first done cycle).
module tb_div_rem_sequencer;

  localparam int XLEN     = 64;
  localparam int CORE_LAT = XLEN + 2;
  localparam int FLUSH    = XLEN + 3;
  localparam int NORM_LAT = 2 + CORE_LAT;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_op = '0;
  logic            req_word = 1'b0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic [XLEN-1:0] req_rs2 = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_result;
  logic            core_start;
  logic [XLEN-1:0] core_dividend;
  logic [XLEN-1:0] core_divisor;
  logic            core_done = 1'b0;
  logic [XLEN-1:0] core_quotient = '0;
  logic [XLEN-1:0] core_remainder = '0;
  logic [2:0]      dbg_state;

  int n_vec = 0;
  int n_fail = 0;
  int n_starts = 0;
  int core_t = -1;
  logic [XLEN-1:0] m_a, m_b;

  // clock / reset
  always #5 clk = ~clk;

  div_rem_sequencer #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_word       (req_word),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_result    (resp_result),
    .core_start     (core_start),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_done      (core_done),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder),
    .dbg_state      (dbg_state)
  );

  // Reset-less core model; second done cycle carries garbage data.
  always @(negedge clk) begin
    if (core_start) begin
      m_a = core_dividend;
      m_b = core_divisor;
      core_t = 0;
      n_starts++;
    end else if (core_t >= 0) begin
      core_t++;
    end
    if (core_t == CORE_LAT) begin
      core_done      = 1'b1;
      core_quotient  = (m_b == '0) ? '1 : m_a / m_b;
      core_remainder = (m_b == '0) ? m_a : m_a % m_b;
    end else if (core_t == CORE_LAT + 1) begin
      core_done      = 1'b1;
      core_quotient  = ~core_quotient;
      core_remainder = ~core_remainder;
    end else begin
      core_done = 1'b0;
      if (core_t > CORE_LAT + 1) core_t = -1;
    end
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_flush(output int cyc);
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      cyc++;
    end
  endtask

  task automatic accept(input logic [1:0] op, input logic word,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int guard;
    req_valid = 1'b1;
    req_op    = op;
    req_word  = word;
    req_rs1   = a;
    req_rs2   = b;
    guard     = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) chk("accept_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // driver: one request through to response handshake
  task automatic do_op(input string tag, input logic [1:0] op, input logic word,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int exp_lat, input int hold);
    int lat;
    int s0;
    s0 = n_starts;
    accept(op, word, a, b);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) break;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, resp_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, "_hold_res"}, resp_result, exp);
      chk({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, "_starts"}, 64'(n_starts - s0), (exp_lat == 1) ? 64'd0 : 64'd1);
  endtask

  initial begin
    int cyc;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_result", resp_result, 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_dividend", core_dividend, 64'd0);
    chk("rst_divisor", core_divisor, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_flush(cyc);
    chk("flush_len", 64'(cyc), 64'(FLUSH));
    @(posedge clk);
    #1;

    // signed basics
    do_op("div_m7_2", DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, NORM_LAT, 0);
    do_op("rem_m7_2", REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, NORM_LAT, 0);
    do_op("div_7_m2", DIV, 1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, NORM_LAT, 0);
    do_op("rem_7_m2", REM, 1'b0, 64'd7, -64'sd2, 64'd1, NORM_LAT, 0);
    do_op("divu_big", DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, NORM_LAT, 0);

    // divide by zero
    do_op("divu_z", DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("remu_z", REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 0);
    do_op("rem_m5_z", REM, 1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 0);

    // signed overflow
    do_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, 0);
    do_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    do_op("divw_ovf", DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, 0);

    // W variants
    do_op("divw_m7_2", DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, NORM_LAT, 0);
    do_op("divuw_1", DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, NORM_LAT, 0);
    do_op("remuw_100_7", REMU, 1'b1, 64'd100, 64'd7, 64'd2, NORM_LAT, 0);
    do_op("remw_m7_2", REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, NORM_LAT, 0);

    // backpressure then back-to-back
    do_op("divu_hold", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, NORM_LAT, 5);
    do_op("divu_b2b", DIVU, 1'b0, 64'd200, 64'd7, 64'd28, NORM_LAT, 0);

    // reset in WAIT, stale core_done drains during flush
    accept(DIVU, 1'b0, 64'd100, 64'd7);
    repeat (11) @(posedge clk);
    #1;
    chk("pre_rst_state_wait", 64'(dbg_state), 64'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    wait_flush(cyc);
    chk("midrst_flush_len", 64'(cyc), 64'(FLUSH));
    @(posedge clk);
    #1;
    do_op("divu_after_rst", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, NORM_LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
